leb128_byte_framer: RTL and testbench

//  Stream framer placed directly upstream of the signed/unsigned LEB128 unpackers.
//  It accepts LEB128 bytes one per cycle over a valid/ready handshake and assembles one

---
 rtl/leb128_byte_framer.sv | 97 +++++++++
 tb/tb_leb128_byte_framer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_byte_framer.sv
// LEB128 byte framer: collects one encoded number per frame into a
// big-endian byte window and flags encodings longer than MAX_BYTES.
module leb128_byte_framer #(
   parameter int MAX_BYTES = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [0:MAX_BYTES*8-1]   out_win,
   output logic [3:0]               out_len,
   output logic                     out_err,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam logic [1:0] S_ACC   = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);
   localparam logic [3:0] FULL_LEN = 4'(MAX_BYTES);

   logic [1:0]             state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [0:MAX_BYTES*8-1] win_q, win_d;
   logic [3:0]             len_q, len_d;
   logic                   err_q, err_d;
   logic                   accept;
   logic                   handoff;

   assign in_ready  = (state_q != S_HOLD);
   assign out_valid = (state_q == S_HOLD);
   assign out_win   = win_q;
   assign out_len   = len_q;
   assign out_err   = err_q;

   assign accept  = in_valid & in_ready;
   assign handoff = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      len_d   = len_q;
      err_d   = err_q;
      unique case (state_q)
         S_ACC: begin
            if (accept) begin
               for (int k = 0; k < MAX_BYTES; k++) begin
                  if (cnt_q == 4'(k)) win_d[k*8 +: 8] = in_data;
               end
               cnt_d = cnt_q + 4'd1;
               if (!in_data[7]) begin
                  state_d = S_HOLD;
                  len_d   = cnt_q + 4'd1;
                  err_d   = 1'b0;
               end else if (cnt_q == LAST_IDX) begin
                  state_d = S_HOLD;
                  len_d   = FULL_LEN;
                  err_d   = 1'b1;
               end
            end
         end
         S_HOLD: begin
            // window is cleared here so slots past the next length read zero
            if (handoff) begin
               cnt_d   = 4'd0;
               win_d   = '0;
               state_d = err_q ? S_DRAIN : S_ACC;
            end
         end
         S_DRAIN: begin
            if (accept && !in_data[7]) state_d = S_ACC;
         end
         default: state_d = S_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ACC;
         cnt_q   <= 4'd0;
         win_q   <= '0;
         len_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_leb128_byte_framer.sv
// Bench for leb128_byte_framer: stream-level framing model plus
// directed LEB128 vectors and randomized streams.
module tb_leb128_byte_framer;

   typedef struct {
      logic [0:79] win;
      int          len;
      bit          err;
   } frame_t;

   typedef logic [7:0] bq_t[$];
   typedef frame_t     fq_t[$];
   typedef bit         tq_t[$];

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [0:79] out_win;
   logic [3:0]  out_len;
   logic        out_err;
   logic        out_valid;
   logic        out_ready;

   int n_cmp;
   int n_bad;
   logic [0:79] got_q[$];

   leb128_byte_framer #(.MAX_BYTES(10)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_win(out_win),
      .out_len(out_len),
      .out_err(out_err),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [79:0] act,
                      input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Splits a byte stream into frames following the LEB128 framing rules.
   task automatic build(input bq_t b, output fq_t fq, output tq_t term);
      logic [0:79] cur;
      int n;
      bit drain;
      fq = {};
      term = {};
      cur = '0;
      n = 0;
      drain = 0;
      foreach (b[i]) begin
         bit t;
         frame_t f;
         t = 0;
         if (drain) begin
            if (!b[i][7]) drain = 0;
         end else begin
            cur[n*8 +: 8] = b[i];
            n++;
            if (!b[i][7] || n == 10) begin
               f.win = cur;
               f.len = n;
               f.err = b[i][7];
               fq.push_back(f);
               t = 1;
               drain = b[i][7];
               cur = '0;
               n = 0;
            end
         end
         term.push_back(t);
      end
   endtask

   function automatic longint decode(input logic [0:79] w, input int len,
                                     input bit sgn);
      longint v;
      logic [7:0] by;
      v = 0;
      for (int k = 0; k < len; k++) begin
         by = w[k*8 +: 8];
         v = v | (longint'(by[6:0]) << (7 * k));
      end
      if (sgn && by[6]) v = v - (longint'(1) << (7 * len));
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // vmode: 0 random valid, 1 always valid. rmode: 0 random,
   // 1 always ready, 2 ready held low for 5 cycles per frame.
   task automatic run_stream(input bq_t bytes, input int vmode,
                             input int rmode, output int zeros);
      fq_t fq;
      tq_t term;
      int idx;
      int lowcnt;
      bit m_valid, acc_p, hs_p, done;
      build(bytes, fq, term);
      idx = 0;
      lowcnt = 0;
      m_valid = 0;
      acc_p = 0;
      hs_p = 0;
      done = 0;
      zeros = 0;
      for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
         @(negedge clk);
         if (hs_p) begin
            void'(fq.pop_front());
            m_valid = 0;
            lowcnt = 0;
         end
         if (acc_p) begin
            if (term[idx]) m_valid = 1;
            idx++;
         end
         chk("out_valid", 80'(out_valid), 80'(m_valid));
         chk("in_ready", 80'(in_ready), 80'(!m_valid));
         if (!in_ready) zeros++;
         if (m_valid && fq.size() > 0) begin
            chk("out_win", out_win, fq[0].win);
            chk("out_len", 80'(out_len), 80'(fq[0].len));
            chk("out_err", 80'(out_err), 80'(fq[0].err));
         end
         if (idx >= bytes.size() && fq.size() == 0 && !m_valid) begin
            done = 1;
            in_valid = 1'b0;
            out_ready = 1'b0;
         end else begin
            if (idx < bytes.size()) begin
               if (!(in_valid && m_valid))
                  in_valid = (vmode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
               in_data = in_valid ? bytes[idx] : 8'($urandom);
            end else begin
               in_valid = 1'b0;
            end
            if (rmode == 1) out_ready = 1'b1;
            else if (rmode == 0) out_ready = ($urandom_range(0, 2) != 0);
            else begin
               out_ready = m_valid && (lowcnt >= 5);
               if (m_valid) lowcnt++;
            end
            #1;
            acc_p = in_valid && !m_valid;
            hs_p = m_valid && out_ready;
            if (hs_p) got_q.push_back(out_win);
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: idx %0d of %0d", idx, bytes.size());
      end
   endtask

   initial begin
      bq_t b;
      fq_t fq;
      tq_t tq;
      int z;
      logic [0:79] ew;
      n_cmp = 0;
      n_bad = 0;

      // pin the model with hand-computed frames
      build({8'hE5, 8'h8E, 8'h26}, fq, tq);
      ew = {24'hE58E26, 56'h0};
      chk("model_t2_win", fq[0].win, ew);
      chk("model_t2_len", 80'(fq[0].len), 80'd3);
      b = {};
      repeat (10) b.push_back(8'h80);
      b.push_back(8'h80);
      b.push_back(8'h01);
      b.push_back(8'h07);
      build(b, fq, tq);
      chk("model_t4_n", 80'(fq.size()), 80'd2);
      chk("model_t4_err", 80'(fq[0].err), 80'd1);
      ew = {8'h07, 72'h0};
      chk("model_t4_win2", fq[1].win, ew);

      do_reset();
      @(negedge clk);
      chk("rst_valid", 80'(out_valid), 80'd0);
      chk("rst_ready", 80'(in_ready), 80'd1);
      chk("rst_win", out_win, 80'h0);
      chk("rst_len", 80'(out_len), 80'd0);
      chk("rst_err", 80'(out_err), 80'd0);

      run_stream({8'h05}, 1, 1, z);
      ew = {8'h05, 72'h0};
      chk("t1_win", got_q[$], ew);

      run_stream({8'hE5, 8'h8E, 8'h26}, 1, 1, z);
      chk("t2_udec", 80'(decode(got_q[$], 3, 0)), 80'd624485);

      run_stream({8'hC0, 8'hBB, 8'h78}, 1, 2, z);
      chk("t3_sdec", 80'(decode(got_q[$], 3, 1)), 80'(-64'sd123456));
      chk("t3_stall", 80'(z), 80'd6);

      run_stream(b, 1, 1, z);
      ew = {8'h07, 72'h0};
      chk("t4_last", got_q[$], ew);

      // reset in the middle of a 3-byte frame
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = 8'h81;
      @(negedge clk);
      in_data = 8'h82;
      @(negedge clk);
      in_data = 8'h03;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_valid", 80'(out_valid), 80'd0);
      chk("t5_ready", 80'(in_ready), 80'd1);
      rst = 1'b0;
      in_valid = 1'b0;
      run_stream({8'h7F}, 1, 1, z);
      ew = {8'h7F, 72'h0};
      chk("t5_win", got_q[$], ew);

      got_q = {};
      run_stream({8'h01, 8'h02, 8'h03}, 1, 1, z);
      chk("t6_zeros", 80'(z), 80'd3);
      chk("t6_n", 80'(got_q.size()), 80'd3);
      if (got_q.size() == 3) begin
         ew = {8'h03, 72'h0};
         chk("t6_order", got_q[2], ew);
      end

      for (int pass = 0; pass < 2; pass++) begin
         b = {};
         for (int n = 0; n < 40; n++) begin
            int len;
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(9, 13)
                                              : $urandom_range(1, 4);
            for (int k = 0; k < len; k++)
               b.push_back({k != len - 1, 7'($urandom)});
         end
         run_stream(b, pass, pass, z);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
